mpi_ahb3_slave: RTL and testbench
=================================

Name: mpi_ahb3_slave

Overview:
Next-generation AHB3-Lite front-end for the MPI message buffers. It is a real AHB-Lite slave: address/data phase pipelining, wait states and two-cycle ERROR responses. It decodes the address to one of N generic bus channels, each of which drives one mpi_buffer instance. Per-channel interrupts are aggregated into a single registered irq.

Parameters:
PLEN, 32, AHB address width
XLEN, 32, AHB data width; also the channel data width
N, 2, number of MPI buffer channels (>=1)
CH_SHIFT, 12, LSB of the channel index field in haddr; each channel owns 2^CH_SHIFT bytes
TIMEOUT, 255, cycles to wait for channel ack before ERROR (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
ahb3_hsel_i  in  1  slave select
ahb3_haddr_i  in  PLEN  address
ahb3_hwdata_i  in  XLEN  write data (data phase)
ahb3_hwrite_i  in  1  1=write
ahb3_hsize_i  in  3  transfer size
ahb3_hburst_i  in  3  burst type (ignored, each beat handled singly)
ahb3_hprot_i  in  4  protection (ignored)
ahb3_htrans_i  in  2  transfer type
ahb3_hmastlock_i  in  1  locked transfer (ignored)
ahb3_hready_i  in  1  bus-wide HREADY
ahb3_hrdata_o  out  XLEN  read data
ahb3_hreadyout_o  out  1  slave ready
ahb3_hresp_o  out  1  1=ERROR
ch_addr_o  out  N*32  per-channel byte offset = haddr[CH_SHIFT-1:0], zero-extended
ch_we_o  out  N  per-channel write enable
ch_en_o  out  N  per-channel access enable (one-hot or zero)
ch_data_o  out  N*XLEN  per-channel write data
ch_data_i  in  N*XLEN  per-channel read data
ch_ack_i  in  N  per-channel ack
ch_err_i  in  N  per-channel error
ch_irq_i  in  N  per-channel interrupt
irq_o  out  1  aggregated interrupt

Behaviour:
- Reset values: state IDLE, hreadyout_o=1, hresp_o=0, hrdata_o=0, ch_en_o=0, ch_we_o=0, irq_o=0. Reset mid-transfer aborts to IDLE immediately. No ack is owed to the channel.
- Valid transfer: hsel_i & hready_i & htrans_i[1] (NONSEQ or SEQ). IDLE and BUSY get a zero-wait OKAY.
- On a valid transfer, latch haddr, hwrite and sel = haddr[CH_SHIFT +: CHW], where CHW = max(1, clog2(N)).
- Error decode: hsize_i != 3'b010, haddr[1:0] != 0, or sel >= N -> ERR1. Otherwise -> ACCESS.
- States:
  - IDLE: hreadyout=1, hresp=0.
  - ACCESS: hreadyout=0. ch_en_o[sel]=1, ch_we_o[sel]=latched write. ch_data_o[sel] = ahb3_hwdata_i (held by the master while hreadyout is low). ch_addr_o is driven from the latched address. Non-selected channels get en=0.
  - ACCESS, ch_err_i[sel]=1 -> ERR1. Error wins over a simultaneous ack.
  - ACCESS, else ch_ack_i[sel]=1 -> RESP, with hrdata_o <= ch_data_i[sel] (registered). Write data is considered consumed.
  - ACCESS, otherwise stay.
  - RESP: hreadyout=1, hresp=0, ch_en=0. A valid transfer sampled here goes directly to ACCESS/ERR1 (back-to-back pipelining). Otherwise -> IDLE.
  - ERR1: hreadyout=0, hresp=1, ch_en=0. Always -> ERR2.
  - ERR2: hreadyout=1, hresp=1. New transfers are decoded exactly as in RESP.
- Minimum OKAY data phase: 2 cycles (ACCESS with ack, then RESP). Error phase: exactly 2 cycles.
- hrdata_o holds its last value outside RESP. On writes it is updated with ch_data_i regardless.
- irq_o = registered OR of ch_irq_i; 1-cycle latency.

Optional Feature:
MPI_AHB3_TIMEOUT_EN:
- Defined: a counter clears on ACCESS entry and increments each ACCESS cycle without ack/err. When the count reaches TIMEOUT -> ERR1 and ch_en is dropped.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- N=2, CH_SHIFT=12, write haddr=0x0000_1004, hwdata=0xDEADBEEF, ack on 2nd ACCESS cycle -> ch_en_o=2'b10, ch_addr_o[63:32]=0x004, ch_data_o[63:32]=0xDEADBEEF; hreadyout low 2 cycles, then one OKAY cycle.
- Pipelined reads of ch0 (0x000) then ch1 (0x1000), ch_data_i=0x11111111/0x22222222, ack immediately -> hrdata_o=0x11111111 in first RESP; ACCESS on ch1 starts next cycle; hrdata_o=0x22222222 in second RESP.
- Byte write (hsize=000) or haddr=0x2, then N=3 with haddr=0x3000 -> ERR1 (hready=0, hresp=1), ERR2 (hready=1, hresp=1); ch_en_o stays 0.
- ch_err_i[0] and ch_ack_i[0] both high in the same cycle -> ERROR response, hrdata_o unchanged.
- With MPI_AHB3_TIMEOUT_EN and TIMEOUT=8, no ack -> ERR1 after 8 ACCESS cycles. Without the macro, hreadyout stays 0 for 100 cycles; ack at cycle 100 -> OKAY.
- Assert rst=0 mid-ACCESS -> the same cycle shows hreadyout=1, ch_en=0, irq_o=0. After release, a read completes normally. ch_irq_i[1]=1 -> irq_o=1 one cycle later.

Source files
------------

// File: rtl/mpi_ahb3_slave_if.sv
// ============================================================================
// mpi_ahb3_slave_if : AHB3-Lite bus bundle between master/interconnect and slave
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mpi_ahb3_slave_if #(
  parameter int PLEN = 32,
  parameter int XLEN = 32
);
  logic            hsel;
  logic [PLEN-1:0] haddr;
  logic [XLEN-1:0] hwdata;
  logic            hwrite;
  logic [2:0]      hsize;
  logic [2:0]      hburst;
  logic [3:0]      hprot;
  logic [1:0]      htrans;
  logic            hmastlock;
  logic            hready;
  logic [XLEN-1:0] hrdata;
  logic            hreadyout;
  logic            hresp;

  modport master (
    output hsel, haddr, hwdata, hwrite, hsize, hburst, hprot, htrans,
           hmastlock, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, hwdata, hwrite, hsize, hburst, hprot, htrans,
           hmastlock, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

`default_nettype wire

// File: rtl/mpi_ahb3_slave.sv
// ============================================================================
// mpi_ahb3_slave : AHB3-Lite slave front-end fanning out to N MPI buffer channels
// Optional: define MPI_AHB3_TIMEOUT_EN to abort unacknowledged accesses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mpi_ahb3_slave #(
  parameter int PLEN     = 32,
  parameter int XLEN     = 32,
  parameter int N        = 2,
  parameter int CH_SHIFT = 12,
  parameter int TIMEOUT  = 255
) (
  input  wire logic              clk,
  input  wire logic              rst,
  mpi_ahb3_slave_if.slave        ahb,
  output logic [N*32-1:0]        ch_addr_o,
  output logic [N-1:0]           ch_we_o,
  output logic [N-1:0]           ch_en_o,
  output logic [N*XLEN-1:0]      ch_data_o,
  input  wire logic [N*XLEN-1:0] ch_data_i,
  input  wire logic [N-1:0]      ch_ack_i,
  input  wire logic [N-1:0]      ch_err_i,
  input  wire logic [N-1:0]      ch_irq_i,
  output logic                   irq_o
);

  localparam int CHW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CHW:0] C_N = (CHW+1)'(N);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RESP   = 3'd2,
    ERR1   = 3'd3,
    ERR2   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CH_SHIFT-1:0] off_q, off_d;
  logic                we_q, we_d;
  logic [CHW-1:0]      sel_q, sel_d;
  logic [XLEN-1:0]     hrdata_q, hrdata_d;
  logic                irq_q;

  logic                valid;
  logic [CHW-1:0]      req_sel;
  logic                req_err;
  logic                sel_ack;
  logic                sel_err;
  logic [XLEN-1:0]     sel_rdata;
  logic                timeout;

  assign valid   = ahb.hsel & ahb.hready & ahb.htrans[1];
  assign req_sel = ahb.haddr[CH_SHIFT +: CHW];
  assign req_err = (ahb.hsize != 3'b010) || (ahb.haddr[1:0] != 2'b00) ||
                   ({1'b0, req_sel} >= C_N);

  // Pick the response of the channel captured in the address phase.
  always_comb begin
    sel_ack   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_q == CHW'(i)) begin
        sel_ack   = ch_ack_i[i];
        sel_err   = ch_err_i[i];
        sel_rdata = ch_data_i[i*XLEN +: XLEN];
      end
    end
  end

`ifdef MPI_AHB3_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] cnt_q, cnt_d;
  assign timeout = (cnt_q == TW'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    we_d     = we_q;
    sel_d    = sel_q;
    hrdata_d = hrdata_q;
`ifdef MPI_AHB3_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      // Every state that shows hreadyout=1 may sample a pipelined transfer.
      IDLE, RESP, ERR2: begin
        state_d = IDLE;
        if (valid) begin
          off_d   = ahb.haddr[CH_SHIFT-1:0];
          we_d    = ahb.hwrite;
          sel_d   = req_sel;
          state_d = req_err ? ERR1 : ACCESS;
`ifdef MPI_AHB3_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ACCESS: begin
        if (sel_err) begin
          state_d = ERR1;
        end else if (sel_ack) begin
          state_d  = RESP;
          hrdata_d = sel_rdata;
        end else if (timeout) begin
          state_d = ERR1;
        end else begin
`ifdef MPI_AHB3_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      off_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      hrdata_q <= '0;
      irq_q    <= 1'b0;
`ifdef MPI_AHB3_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      hrdata_q <= hrdata_d;
      irq_q    <= |ch_irq_i;
`ifdef MPI_AHB3_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign ahb.hrdata    = hrdata_q;
  assign ahb.hreadyout = (state_q != ACCESS) && (state_q != ERR1);
  assign ahb.hresp     = (state_q == ERR1) || (state_q == ERR2);
  assign irq_o         = irq_q;

  always_comb begin
    ch_en_o = '0;
    ch_we_o = '0;
    for (int i = 0; i < N; i++) begin
      ch_en_o[i] = (state_q == ACCESS) && (sel_q == CHW'(i));
      ch_we_o[i] = (state_q == ACCESS) && (sel_q == CHW'(i)) && we_q;
    end
  end

  // Write data comes straight from the bus; the master holds it while stalled.
  generate
    for (genvar g = 0; g < N; g++) begin : g_ch
      assign ch_addr_o[g*32 +: 32]     = 32'(off_q);
      assign ch_data_o[g*XLEN +: XLEN] = ahb.hwdata;
    end
  endgenerate

  logic unused_ok;
  assign unused_ok = ^{ahb.haddr, ahb.hburst, ahb.hprot, ahb.htrans,
                       ahb.hmastlock};

endmodule

`default_nettype wire

// File: tb/tb_mpi_ahb3_slave.sv
// ============================================================================
// tb_mpi_ahb3_slave : directed self-checking bench for mpi_ahb3_slave
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mpi_ahb3_slave;

  logic clk;
  logic rst;

  mpi_ahb3_slave_if #(.PLEN(32), .XLEN(32)) bus ();
  mpi_ahb3_slave_if #(.PLEN(32), .XLEN(32)) bus3 ();

  // Single-slave systems: bus-wide HREADY is the slave's own HREADYOUT.
  assign bus.hready  = bus.hreadyout;
  assign bus3.hready = bus3.hreadyout;

  logic [63:0] ch_addr, ch_data_o, ch_data_i;
  logic [1:0]  ch_we, ch_en, ch_ack, ch_err, ch_irq;
  logic        irq;

  logic [95:0] unused_addr3, unused_data3;
  logic [2:0]  ch_we3, ch_en3;
  logic        irq3;

  int n_tests = 0;
  int n_fail  = 0;

  mpi_ahb3_slave #(.PLEN(32), .XLEN(32), .N(2), .CH_SHIFT(12), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .ahb(bus.slave),
    .ch_addr_o(ch_addr), .ch_we_o(ch_we), .ch_en_o(ch_en),
    .ch_data_o(ch_data_o), .ch_data_i(ch_data_i),
    .ch_ack_i(ch_ack), .ch_err_i(ch_err), .ch_irq_i(ch_irq), .irq_o(irq)
  );

  mpi_ahb3_slave #(.PLEN(32), .XLEN(32), .N(3), .CH_SHIFT(12), .TIMEOUT(8)) dut3 (
    .clk(clk), .rst(rst), .ahb(bus3.slave),
    .ch_addr_o(unused_addr3), .ch_we_o(ch_we3), .ch_en_o(ch_en3),
    .ch_data_o(unused_data3), .ch_data_i(96'h0),
    .ch_ack_i(3'b000), .ch_err_i(3'b000), .ch_irq_i(3'b000), .irq_o(irq3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] size);
    bus.hsel   = 1'b1;
    bus.haddr  = a;
    bus.hwrite = w;
    bus.hsize  = size;
    bus.htrans = 2'b10;
  endtask

  task automatic bus_idle();
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
  endtask

  int high_cnt;

  initial begin
    rst = 1'b0;
    bus.hsel = 0; bus.haddr = 0; bus.hwdata = 0; bus.hwrite = 0; bus.hsize = 3'b010;
    bus.hburst = 0; bus.hprot = 0; bus.htrans = 0; bus.hmastlock = 0;
    bus3.hsel = 0; bus3.haddr = 0; bus3.hwdata = 0; bus3.hwrite = 0; bus3.hsize = 3'b010;
    bus3.hburst = 0; bus3.hprot = 0; bus3.htrans = 0; bus3.hmastlock = 0;
    ch_data_i = 0; ch_ack = 0; ch_err = 0; ch_irq = 0;

    repeat (2) tick();
    check("rst_hreadyout", bus.hreadyout, 1);
    check("rst_hresp", bus.hresp, 0);
    check("rst_hrdata", bus.hrdata, 0);
    check("rst_en_we", {ch_en, ch_we}, 0);
    check("rst_irq", irq, 0);
    rst = 1'b1;
    tick();

    // Write to channel 1, ack on the second ACCESS cycle.
    addr_phase(32'h0000_1004, 1'b1, 3'b010);
    tick();
    bus_idle();
    bus.hwdata = 32'hDEADBEEF;
    ch_data_i  = {32'hCAFEF00D, 32'h0};
    check("wr_ready_c1", bus.hreadyout, 0);
    check("wr_en", ch_en, 2'b10);
    check("wr_we", ch_we, 2'b10);
    check("wr_addr", ch_addr[63:32], 32'h004);
    check("wr_data", ch_data_o[63:32], 32'hDEADBEEF);
    tick();
    check("wr_ready_c2", bus.hreadyout, 0);
    ch_ack = 2'b10;
    tick();
    ch_ack = 2'b00;
    check("wr_resp", {bus.hreadyout, bus.hresp, ch_en}, {1'b1, 1'b0, 2'b00});
    check("wr_hrdata", bus.hrdata, 32'hCAFEF00D);
    tick();

    // Pipelined reads: ch0 then ch1.
    addr_phase(32'h0000_0000, 1'b0, 3'b010);
    tick();
    ch_data_i = {32'h22222222, 32'h11111111};
    ch_ack    = 2'b01;
    addr_phase(32'h0000_1000, 1'b0, 3'b010);
    check("rd0_en", {ch_en, ch_we}, {2'b01, 2'b00});
    tick();
    ch_ack = 2'b00;
    check("rd0_resp", {bus.hreadyout, bus.hresp}, 2'b10);
    check("rd0_hrdata", bus.hrdata, 32'h11111111);
    tick();
    bus_idle();
    check("rd1_en", ch_en, 2'b10);
    ch_ack = 2'b10;
    tick();
    ch_ack = 2'b00;
    check("rd1_hrdata", bus.hrdata, 32'h22222222);
    tick();

    // Byte write, then a misaligned read issued during ERR2.
    addr_phase(32'h0000_0000, 1'b1, 3'b000);
    tick();
    check("byte_err1", {bus.hreadyout, bus.hresp, ch_en}, {1'b0, 1'b1, 2'b00});
    tick();
    check("byte_err2", {bus.hreadyout, bus.hresp}, 2'b11);
    addr_phase(32'h0000_0002, 1'b0, 3'b010);
    tick();
    bus_idle();
    check("misal_err1", {bus.hreadyout, bus.hresp, ch_en}, {1'b0, 1'b1, 2'b00});
    tick();
    check("misal_err2", {bus.hreadyout, bus.hresp}, 2'b11);
    tick();
    check("err_to_idle", {bus.hreadyout, bus.hresp}, 2'b10);

    // Out-of-range channel on a three-channel instance.
    bus3.hsel = 1'b1; bus3.haddr = 32'h0000_3000; bus3.hsize = 3'b010; bus3.htrans = 2'b10;
    tick();
    bus3.hsel = 1'b0; bus3.htrans = 2'b00;
    check("n3_err1", {bus3.hreadyout, bus3.hresp, ch_en3, ch_we3}, {1'b0, 1'b1, 6'b0});
    tick();
    check("n3_err2", {bus3.hreadyout, bus3.hresp, ch_en3}, {1'b1, 1'b1, 3'b0});
    tick();

    // Error and ack in the same cycle: error wins, read data untouched.
    addr_phase(32'h0000_0008, 1'b0, 3'b010);
    tick();
    bus_idle();
    ch_data_i = {32'h22222222, 32'h99999999};
    ch_err = 2'b01;
    ch_ack = 2'b01;
    tick();
    ch_err = 2'b00;
    ch_ack = 2'b00;
    check("erack_err1", {bus.hreadyout, bus.hresp}, 2'b01);
    check("erack_hrdata", bus.hrdata, 32'h22222222);
    tick();
    check("erack_err2", {bus.hreadyout, bus.hresp}, 2'b11);
    tick();

    // Unacknowledged access.
    addr_phase(32'h0000_1010, 1'b0, 3'b010);
    tick();
    bus_idle();
    ch_data_i = {32'h600DCAFE, 32'h0};
    high_cnt = 0;
`ifdef MPI_AHB3_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      if (bus.hreadyout) high_cnt++;
      tick();
    end
    if (bus.hreadyout) high_cnt++;
    check("to_wait_low", high_cnt, 0);
    tick();
    check("to_err1", {bus.hreadyout, bus.hresp, ch_en}, {1'b0, 1'b1, 2'b00});
    tick();
    check("to_err2", {bus.hreadyout, bus.hresp}, 2'b11);
    tick();
`else
    for (int i = 1; i < 100; i++) begin
      if (bus.hreadyout) high_cnt++;
      tick();
    end
    if (bus.hreadyout) high_cnt++;
    check("wait_low", high_cnt, 0);
    ch_ack = 2'b10;
    tick();
    ch_ack = 2'b00;
    check("wait_resp", {bus.hreadyout, bus.hresp}, 2'b10);
    check("wait_hrdata", bus.hrdata, 32'h600DCAFE);
    tick();
`endif

    // Interrupt latency, then reset asserted mid-ACCESS.
    addr_phase(32'h0000_0000, 1'b0, 3'b010);
    ch_irq = 2'b10;
    #0;
    check("irq_pre", irq, 0);
    tick();
    bus_idle();
    check("irq_post", irq, 1);
    check("rstmid_en", ch_en, 2'b01);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_ready", {bus.hreadyout, bus.hresp, ch_en}, {1'b1, 1'b0, 2'b00});
    check("rstmid_irq", irq, 0);
    check("rstmid_hrdata", bus.hrdata, 0);
    ch_irq = 2'b00;
    tick();
    rst = 1'b1;
    tick();

    addr_phase(32'h0000_0020, 1'b0, 3'b010);
    tick();
    bus_idle();
    check("post_en", ch_en, 2'b01);
    check("post_addr", ch_addr[31:0], 32'h20);
    ch_data_i = {32'h0, 32'h5A5A5A5A};
    ch_ack = 2'b01;
    tick();
    ch_ack = 2'b00;
    check("post_resp", {bus.hreadyout, bus.hresp}, 2'b10);
    check("post_hrdata", bus.hrdata, 32'h5A5A5A5A);
    tick();
    check("post_idle", {bus.hreadyout, ch_en, irq}, {1'b1, 2'b00, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
